// File: rtl/display_scan_mux.sv
// display_scan_mux: registered N:1 time-multiplexing selector for multi-digit
// displays. The module either auto-scans the channels or holds one manually
// selected channel. It drives zero-extended channel data and an active-low
// one-hot digit strobe. Every channel change is followed by a programmable
// number of blank cycles to suppress ghosting.
module display_scan_mux #(
    parameter int N_CH   = 4,
    parameter int DATA_W = 6,
    parameter int OUT_W  = 7,
    parameter int DIV    = 4,
    parameter int BLANK  = 1,
    parameter int IDX_W  = (N_CH > 2) ? $clog2(N_CH) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_CH*DATA_W-1:0] data_in,
    input  logic                   enable,
    input  logic                   mode,
    input  logic [IDX_W-1:0]       man_sel,
    output logic [OUT_W-1:0]       data_out,
    output logic [N_CH-1:0]        an_n,
    output logic [IDX_W-1:0]       cur_idx,
    output logic                   tick
);

    localparam int PRESC_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BLANK_W = (BLANK > 0) ? $clog2(BLANK + 1) : 1;

    localparam logic [PRESC_W-1:0] PRESC_MAX  = PRESC_W'(DIV - 1);
    localparam logic [PRESC_W-1:0] PRESC_ONE  = PRESC_W'(1);
    localparam logic [BLANK_W-1:0] BLANK_LOAD = BLANK_W'(BLANK);
    localparam logic [BLANK_W-1:0] BLANK_ONE  = BLANK_W'(1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(N_CH - 1);
    localparam logic [IDX_W-1:0]   IDX_ONE    = IDX_W'(1);
    localparam logic [IDX_W:0]     N_CH_EXT   = (IDX_W + 1)'(N_CH);
    localparam logic [N_CH-1:0]    STROBE_ONE = N_CH'(1);

    logic [PRESC_W-1:0] presc;
    logic [PRESC_W-1:0] presc_n;
    logic               wrap;
    logic [IDX_W-1:0]   idx_n;
    logic [BLANK_W-1:0] blank_cnt;
    logic [BLANK_W-1:0] blank_n;
    logic               blanking;
    logic [DATA_W-1:0]  sel_data;
    logic [N_CH-1:0]    strobe_n;
    logic [DATA_W-1:0]  channel [N_CH];

    // Split the packed input bus into one entry per channel.
    for (genvar k = 0; k < N_CH; k++) begin : g_unpack
        assign channel[k] = data_in[k*DATA_W +: DATA_W];
    end

    // Next-state logic for the prescaler, the channel index, the blank counter and the output values.
    always_comb begin
        wrap    = (presc == PRESC_MAX);
        presc_n = wrap ? '0 : presc + PRESC_ONE;

        idx_n = cur_idx;
        if (mode) begin
            if ({1'b0, man_sel} < N_CH_EXT) begin
                idx_n = man_sel;
            end
        end else if (wrap) begin
            idx_n = (cur_idx == IDX_LAST) ? '0 : cur_idx + IDX_ONE;
        end

        if (idx_n != cur_idx) begin
            blank_n = BLANK_LOAD;
        end else if (blank_cnt != '0) begin
            blank_n = blank_cnt - BLANK_ONE;
        end else begin
            blank_n = '0;
        end

        blanking = (blank_n != '0);
        sel_data = channel[idx_n];
        strobe_n = ~(STROBE_ONE << idx_n);
    end

    // Register all state and outputs on enabled cycles. When enable is low, every register holds except tick, which clears.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc     <= '0;
            cur_idx   <= '0;
            blank_cnt <= '0;
            data_out  <= '0;
            an_n      <= '1;
            tick      <= 1'b0;
        end else if (enable) begin
            presc     <= presc_n;
            tick      <= wrap;
            cur_idx   <= idx_n;
            blank_cnt <= blank_n;
            data_out  <= blanking ? '0 : OUT_W'(sel_data);
            an_n      <= blanking ? '1 : strobe_n;
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: tb/tb_display_scan_mux.sv
// tb_display_scan_mux: directed bench for display_scan_mux. It uses three
// instances: the default build, a 3-channel build and a DIV=1/BLANK=0 build.
// Expected values are hand-computed for each step.
module tb_display_scan_mux;

    logic        clk;
    logic        rst;
    logic [23:0] data_in;
    logic        enable;
    logic        mode;
    logic [1:0]  man_sel;
    logic        mode3;
    logic [1:0]  man_sel3;
    logic        mode1;
    logic [1:0]  man_sel1;

    logic [6:0]  data_out;
    logic [3:0]  an_n;
    logic [1:0]  cur_idx;
    logic        tick;

    logic [6:0]  data_out3;
    logic [2:0]  an_n3;
    logic [1:0]  cur_idx3;
    logic        tick3;

    logic [6:0]  data_out1;
    logic [3:0]  an_n1;
    logic [1:0]  cur_idx1;
    logic        tick1;

    int checks;
    int errors;

    display_scan_mux #(.N_CH(4), .DATA_W(6), .OUT_W(7), .DIV(4), .BLANK(1)) u_dut (
        .clk(clk), .rst(rst), .data_in(data_in), .enable(enable), .mode(mode),
        .man_sel(man_sel), .data_out(data_out), .an_n(an_n), .cur_idx(cur_idx), .tick(tick)
    );

    display_scan_mux #(.N_CH(3), .DATA_W(6), .OUT_W(7), .DIV(4), .BLANK(1)) u_dut3 (
        .clk(clk), .rst(rst), .data_in(data_in[17:0]), .enable(enable), .mode(mode3),
        .man_sel(man_sel3), .data_out(data_out3), .an_n(an_n3), .cur_idx(cur_idx3), .tick(tick3)
    );

    display_scan_mux #(.N_CH(4), .DATA_W(6), .OUT_W(7), .DIV(1), .BLANK(0)) u_dut1 (
        .clk(clk), .rst(rst), .data_in(data_in), .enable(enable), .mode(mode1),
        .man_sel(man_sel1), .data_out(data_out1), .an_n(an_n1), .cur_idx(cur_idx1), .tick(tick1)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive the main instance's controls, then advance one edge and settle past it.
    task automatic applyStimulus(input logic en, input logic md, input logic [1:0] sel);
        enable  = en;
        mode    = md;
        man_sel = sel;
        @(posedge clk);
        #1;
    endtask

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Check all outputs of the main instance.
    task automatic checkMain(input string tag, input logic [6:0] d, input logic [3:0] an,
                             input logic [1:0] idx, input logic tk);
        checkOutput({tag, ".data_out"}, 32'(data_out), 32'(d));
        checkOutput({tag, ".an_n"},     32'(an_n),     32'(an));
        checkOutput({tag, ".cur_idx"},  32'(cur_idx),  32'(idx));
        checkOutput({tag, ".tick"},     32'(tick),     32'(tk));
    endtask

    // Check the outputs of the 3-channel instance.
    task automatic checkDut3(input string tag, input logic [6:0] d, input logic [2:0] an, input logic [1:0] idx);
        checkOutput({tag, ".data_out3"}, 32'(data_out3), 32'(d));
        checkOutput({tag, ".an_n3"},     32'(an_n3),     32'(an));
        checkOutput({tag, ".cur_idx3"},  32'(cur_idx3),  32'(idx));
    endtask

    // Check all outputs of the DIV=1 instance.
    task automatic checkDut1(input string tag, input logic [6:0] d, input logic [3:0] an,
                             input logic [1:0] idx, input logic tk);
        checkOutput({tag, ".data_out1"}, 32'(data_out1), 32'(d));
        checkOutput({tag, ".an_n1"},     32'(an_n1),     32'(an));
        checkOutput({tag, ".cur_idx1"},  32'(cur_idx1),  32'(idx));
        checkOutput({tag, ".tick1"},     32'(tick1),     32'(tk));
    endtask

    // Directed sequence: reset, auto scan, enable gating, live data, manual mode, async reset, then the 3-channel and DIV=1 builds.
    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        enable   = 1'b0;
        mode     = 1'b0;
        man_sel  = 2'd0;
        mode3    = 1'b0;
        man_sel3 = 2'd0;
        mode1    = 1'b0;
        man_sel1 = 2'd0;
        data_in  = {6'h3F, 6'h15, 6'h2A, 6'h01};

        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        $display("[TB] reset state");
        checkMain("reset", 7'h00, 4'b1111, 2'd0, 1'b0);
        rst = 1'b0;

        $display("[TB] auto scan");
        applyStimulus(1, 0, 0);
        checkMain("e1_ch0", 7'h01, 4'b1110, 2'd0, 1'b0);
        repeat (2) applyStimulus(1, 0, 0);
        checkMain("e3_ch0", 7'h01, 4'b1110, 2'd0, 1'b0);
        applyStimulus(1, 0, 0);
        checkMain("e4_blank1", 7'h00, 4'b1111, 2'd1, 1'b1);
        applyStimulus(1, 0, 0);
        checkMain("e5_ch1", 7'h2A, 4'b1101, 2'd1, 1'b0);
        repeat (3) applyStimulus(1, 0, 0);
        checkMain("e8_blank2", 7'h00, 4'b1111, 2'd2, 1'b1);
        applyStimulus(1, 0, 0);
        checkMain("e9_ch2", 7'h15, 4'b1011, 2'd2, 1'b0);
        repeat (3) applyStimulus(1, 0, 0);
        checkMain("e12_blank3", 7'h00, 4'b1111, 2'd3, 1'b1);
        applyStimulus(1, 0, 0);
        checkMain("e13_ch3", 7'h3F, 4'b0111, 2'd3, 1'b0);
        repeat (3) applyStimulus(1, 0, 0);
        checkMain("e16_wrap0", 7'h00, 4'b1111, 2'd0, 1'b1);
        repeat (4) applyStimulus(1, 0, 0);
        checkMain("e20_blank1", 7'h00, 4'b1111, 2'd1, 1'b1);

        $display("[TB] enable gating");
        repeat (10) applyStimulus(0, 0, 0);
        checkMain("frozen", 7'h00, 4'b1111, 2'd1, 1'b0);
        applyStimulus(1, 0, 0);
        checkMain("resume_ch1", 7'h2A, 4'b1101, 2'd1, 1'b0);
        repeat (2) applyStimulus(1, 0, 0);
        checkMain("resume_hold", 7'h2A, 4'b1101, 2'd1, 1'b0);
        applyStimulus(1, 0, 0);
        checkMain("resume_step", 7'h00, 4'b1111, 2'd2, 1'b1);
        applyStimulus(1, 0, 0);
        checkMain("e25_ch2", 7'h15, 4'b1011, 2'd2, 1'b0);

        $display("[TB] live data");
        data_in[17:12] = 6'h0A;
        applyStimulus(1, 0, 0);
        checkMain("live_ch2", 7'h0A, 4'b1011, 2'd2, 1'b0);

        $display("[TB] manual mode");
        applyStimulus(1, 1, 3);
        checkMain("man_blank", 7'h00, 4'b1111, 2'd3, 1'b0);
        applyStimulus(1, 1, 3);
        checkMain("man_ch3", 7'h3F, 4'b0111, 2'd3, 1'b1);
        repeat (4) applyStimulus(1, 1, 3);
        checkMain("man_hold_tick", 7'h3F, 4'b0111, 2'd3, 1'b1);
        applyStimulus(1, 0, 0);
        checkMain("back_auto", 7'h3F, 4'b0111, 2'd3, 1'b0);
        repeat (3) applyStimulus(1, 0, 0);
        checkMain("auto_from3", 7'h00, 4'b1111, 2'd0, 1'b1);
        applyStimulus(1, 0, 0);
        checkMain("auto_ch0", 7'h01, 4'b1110, 2'd0, 1'b0);
        repeat (7) applyStimulus(1, 0, 0);
        checkMain("to_ch2_blank", 7'h00, 4'b1111, 2'd2, 1'b1);
        applyStimulus(1, 0, 0);
        checkMain("at_ch2", 7'h0A, 4'b1011, 2'd2, 1'b0);

        $display("[TB] asynchronous reset mid-scan");
        rst = 1'b1;
        #1;
        checkMain("async_rst", 7'h00, 4'b1111, 2'd0, 1'b0);
        @(posedge clk);
        #1;
        mode3    = 1'b1;
        man_sel3 = 2'd1;
        rst      = 1'b0;

        $display("[TB] first edge after reset, 3-channel and DIV=1 builds");
        applyStimulus(1, 0, 0);
        checkMain("rel_first", 7'h01, 4'b1110, 2'd0, 1'b0);
        checkDut3("f1_n3", 7'h00, 3'b111, 2'd1);
        checkDut1("f1_d1", 7'h2A, 4'b1101, 2'd1, 1'b1);
        applyStimulus(1, 0, 0);
        checkDut3("f2_n3", 7'h2A, 3'b101, 2'd1);
        checkDut1("f2_d1", 7'h0A, 4'b1011, 2'd2, 1'b1);
        man_sel3 = 2'd3;
        applyStimulus(1, 0, 0);
        checkDut3("f3_n3_badsel", 7'h2A, 3'b101, 2'd1);
        checkDut1("f3_d1", 7'h3F, 4'b0111, 2'd3, 1'b1);
        applyStimulus(1, 0, 0);
        checkDut3("f4_n3_badsel", 7'h2A, 3'b101, 2'd1);
        checkDut1("f4_d1_wrap", 7'h01, 4'b1110, 2'd0, 1'b1);
        mode3 = 1'b0;
        repeat (3) applyStimulus(1, 0, 0);
        checkDut3("f7_n3_auto", 7'h2A, 3'b101, 2'd1);
        applyStimulus(1, 0, 0);
        checkDut3("f8_n3_blank", 7'h00, 3'b111, 2'd2);
        applyStimulus(1, 0, 0);
        checkDut3("f9_n3_ch2", 7'h0A, 3'b011, 2'd2);
        repeat (3) applyStimulus(1, 0, 0);
        checkDut3("f12_n3_wrap", 7'h00, 3'b111, 2'd0);
        applyStimulus(1, 0, 0);
        checkDut3("f13_n3_ch0", 7'h01, 3'b110, 2'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
